// File: rtl/haar_lift_stage_if.sv
// rtl/haar_lift_stage_if.sv - sample-in / coefficient-out bundle for the Haar lifting stage
//
// Signals:
//   in_valid   : in_data carries a new sample this cycle (no backpressure)
//   in_data    : signed input sample, DW bits
//   out_valid  : one-cycle pulse, coefficient fields below are valid
//   out_approx : signed approximation s, DW bits
//   out_detail : signed detail d, DW+1 bits
//   out_index  : coefficient index within the frame
//   out_last   : final coefficient of the frame (only with out_valid)
// master = sample producer / coefficient consumer, slave = the lifting stage.
interface haar_lift_stage_if #(
    parameter int DW = 9,
    parameter int IW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_approx;
    logic [DW:0]   out_detail;
    logic [IW-1:0] out_index;
    logic          out_last;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_approx,
        input  out_detail,
        input  out_index,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_approx,
        output out_detail,
        output out_index,
        output out_last
    );
endinterface

// File: rtl/haar_lift_stage.sv
// rtl/haar_lift_stage.sv - one level of the integer lifting Haar transform, frame aware
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : haar_lift_stage_if slave (sample stream in, coefficients out)
// Pairs consecutive samples (a = x[2n], b = x[2n+1]) and emits
//   d = b - a (DW+1 bits), s = a + (d >>> 1) (DW bits).
// An odd-length frame ends on an unpaired sample, which is extended
// symmetrically (b = a), giving d = 0 and s = a.
module haar_lift_stage #(
    parameter int DW        = 9,
    parameter int FRAME_LEN = 201,
    parameter int IW        = 8
) (
    input  logic               clk,
    input  logic               rst,
    haar_lift_stage_if.slave   bus
);
    localparam int              CW       = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [IW-1:0]  idx_q;
    logic [DW-1:0]  a_q;

    logic           valid_q;
    logic [DW-1:0]  approx_q;
    logic [DW:0]    detail_q;
    logic [IW-1:0]  index_q;
    logic           last_q;

    logic               frame_end;
    logic               extend;
    logic [DW-1:0]      a_sel;
    logic signed [DW:0] a_ext;
    logic signed [DW:0] b_ext;
    logic signed [DW:0] d_c;
    logic signed [DW:0] s_c;

    // Extension case: the frame-end sample arrives in EVEN, so it is used as
    // both a and b; d collapses to zero and s to the sample itself.
    always_comb begin
        frame_end = (cnt_q == LAST_CNT);
        extend    = (state_q == EVEN) && frame_end;
        a_sel     = extend ? bus.in_data : a_q;
        a_ext     = {a_sel[DW-1], a_sel};
        b_ext     = {bus.in_data[DW-1], bus.in_data};
        d_c       = b_ext - a_ext;
        s_c       = a_ext + (d_c >>> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EVEN;
            cnt_q    <= '0;
            idx_q    <= '0;
            a_q      <= '0;
            valid_q  <= 1'b0;
            approx_q <= '0;
            detail_q <= '0;
            index_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (bus.in_valid) begin
                cnt_q <= frame_end ? '0 : cnt_q + CW'(1);
                if ((state_q == EVEN) && !frame_end) begin
                    a_q     <= bus.in_data;
                    state_q <= ODD;
                end else begin
                    valid_q  <= 1'b1;
                    approx_q <= s_c[DW-1:0];
                    detail_q <= d_c;
                    index_q  <= idx_q;
                    last_q   <= frame_end;
                    idx_q    <= frame_end ? '0 : idx_q + IW'(1);
                    state_q  <= EVEN;
                end
            end
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_approx = approx_q;
    assign bus.out_detail = detail_q;
    assign bus.out_index  = index_q;
    assign bus.out_last   = last_q;
endmodule

// File: tb/tb_haar_lift_stage.sv
// tb/tb_haar_lift_stage.sv - self-checking bench for haar_lift_stage (frame lengths 201 and 4)
module tb_haar_lift_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    haar_lift_stage_if #(.DW(9), .IW(8)) u_if ();
    haar_lift_stage_if #(.DW(9), .IW(8)) u_if4 ();

    haar_lift_stage #(.DW(9), .FRAME_LEN(201), .IW(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    haar_lift_stage #(.DW(9), .FRAME_LEN(4), .IW(8)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (u_if4.slave)
    );

    typedef struct {
        int a;
        int b;
        int s;
        int d;
    } vec_t;

    vec_t vecs[8];

    int checks = 0;
    int errors = 0;

    int          flen[2] = '{201, 4};
    int          pos[2];
    int          held[2];
    bit          pend[2];
    logic [28:0] exp_out[2];
    logic [26:0] hold_fields[2];
    int          pulses[2];
    int          lasts[2];
    logic [28:0] obs;

    function automatic int fdiv2(input int v);
        return (v - (((v % 2) + 2) % 2)) / 2;
    endfunction

    function automatic logic [28:0] grab(input int j);
        if (j == 0)
            return {u_if.out_valid, u_if.out_approx, u_if.out_detail, u_if.out_index, u_if.out_last};
        return {u_if4.out_valid, u_if4.out_approx, u_if4.out_detail, u_if4.out_index, u_if4.out_last};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: sample position p within the frame decides everything.
    task automatic model_accept(input int j, input int x);
        int p;
        int a;
        int d;
        int s;
        p = pos[j];
        if (p % 2 == 0) held[j] = x;
        if ((p % 2 == 1) || (p == flen[j] - 1)) begin
            a = (p % 2 == 1) ? held[j] : x;
            d = x - a;
            s = a + fdiv2(d);
            exp_out[j] = {1'b1, 9'(s), 10'(d), 8'(p / 2), (p == flen[j] - 1)};
            pend[j] = 1'b1;
        end
        pos[j] = (p + 1) % flen[j];
    endtask

    // One clock: check outputs on the falling edge, then drive the next inputs.
    task automatic step(input bit r, input bit v, input int x);
        logic [28:0] act;
        logic [28:0] exp;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            act = grab(j);
            exp = pend[j] ? exp_out[j] : {1'b0, hold_fields[j], 1'b0};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL stream dut%0d: got %h, expected %h", j, act, exp);
            end
            if (pend[j]) begin
                hold_fields[j] = exp_out[j][27:1];
                pulses[j]++;
                if (exp_out[j][0]) lasts[j]++;
                pend[j] = 1'b0;
            end
            if (j == 0) obs = act;
        end
        rst = r;
        u_if.in_valid  = v;
        u_if.in_data   = 9'(x);
        u_if4.in_valid = v;
        u_if4.in_data  = 9'(x);
        for (int j = 0; j < 2; j++) begin
            if (r) begin
                pos[j] = 0;
                pend[j] = 1'b0;
                hold_fields[j] = '0;
            end else if (v) begin
                model_accept(j, x);
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0);
        for (int j = 0; j < 2; j++) begin
            pulses[j] = 0;
            lasts[j]  = 0;
        end
    endtask

    function automatic int obs_s();
        return int'($signed(obs[27:19]));
    endfunction

    function automatic int obs_d();
        return int'($signed(obs[18:9]));
    endfunction

    initial begin
        vecs[0] = '{a: 10,   b: 4,    s: 7,    d: -6};
        vecs[1] = '{a: -3,   b: 0,    s: -2,   d: 3};
        vecs[2] = '{a: 255,  b: -256, s: -1,   d: -511};
        vecs[3] = '{a: -256, b: 255,  s: -1,   d: 511};
        vecs[4] = '{a: 1,    b: -1,   s: 0,    d: -2};
        vecs[5] = '{a: -256, b: -256, s: -256, d: 0};
        vecs[6] = '{a: 255,  b: 255,  s: 255,  d: 0};
        vecs[7] = '{a: 0,    b: 7,    s: 3,    d: 7};

        for (int j = 0; j < 2; j++) begin
            pos[j] = 0; held[j] = 0; pend[j] = 1'b0;
            exp_out[j] = '0; hold_fields[j] = '0;
            pulses[j] = 0; lasts[j] = 0;
        end
        u_if.in_valid = 1'b0;  u_if.in_data = '0;
        u_if4.in_valid = 1'b0; u_if4.in_data = '0;
        obs = '0;

        // Reset state
        do_reset();
        do_reset();
        step(1'b0, 1'b0, 0);
        chk("reset_outputs_zero", int'(obs), 0);

        // Table-driven pairs, indices 0..7 within one frame
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, vecs[i].a);
            step(1'b0, 1'b1, vecs[i].b);
            step(1'b0, 1'b0, 0);
            chk($sformatf("vec%0d_valid", i), int'(obs[28]), 1);
            chk($sformatf("vec%0d_s", i), obs_s(), vecs[i].s);
            chk($sformatf("vec%0d_d", i), obs_d(), vecs[i].d);
            chk($sformatf("vec%0d_index", i), int'(obs[8:1]), i);
            chk($sformatf("vec%0d_inv_a", i), obs_s() - fdiv2(obs_d()), vecs[i].a);
            chk($sformatf("vec%0d_inv_b", i), obs_s() - fdiv2(obs_d()) + obs_d(), vecs[i].b);
        end

        // Stall between the two samples of a pair
        do_reset();
        step(1'b0, 1'b1, 20);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0);
        chk("stall_no_early_pulse", pulses[0], 0);
        step(1'b0, 1'b1, 22);
        step(1'b0, 1'b0, 0);
        chk("stall_pulses", pulses[0], 1);
        chk("stall_s", obs_s(), 21);
        chk("stall_d", obs_d(), 2);

        // Full odd frame ramp; FRAME_LEN=4 instance sees the same stream
        do_reset();
        for (int i = 0; i <= 200; i++) step(1'b0, 1'b1, i);
        step(1'b0, 1'b0, 0);
        chk("frame_pulses", pulses[0], 101);
        chk("frame_end_s", obs_s(), 200);
        chk("frame_end_d", obs_d(), 0);
        chk("frame_end_index", int'(obs[8:1]), 100);
        chk("frame_end_last", int'(obs[0]), 1);
        chk("frame_lasts", lasts[0], 1);
        chk("even_frame_pulses", pulses[1], 100);
        chk("even_frame_lasts", lasts[1], 50);
        step(1'b0, 1'b1, 5);
        step(1'b0, 1'b1, 6);
        step(1'b0, 1'b0, 0);
        chk("new_frame_index", int'(obs[8:1]), 0);
        chk("new_frame_last", int'(obs[0]), 0);
        chk("new_frame_s", obs_s(), 5);

        // Reset mid-pair, with a sample presented during reset
        do_reset();
        step(1'b0, 1'b1, 50);
        do_reset();
        step(1'b1, 1'b1, 99);
        for (int j = 0; j < 2; j++) pulses[j] = 0;
        step(1'b0, 1'b1, 7);
        step(1'b0, 1'b1, 9);
        step(1'b0, 1'b0, 0);
        chk("midreset_pulses", pulses[0], 1);
        chk("midreset_s", obs_s(), 8);
        chk("midreset_d", obs_d(), 2);
        chk("midreset_index", int'(obs[8:1]), 0);

        // Randomized stream with gaps and occasional resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 599) == 0), ($urandom_range(0, 9) < 7),
                 int'($urandom_range(0, 511)) - 256);
        end
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
